// File: rtl/text_scroll_ctrl_m.sv
// TXBL clear / scroll-up engine sharing the single TXBL write port with the CPU (CPU wins).
// Build option: define TEXT_SCROLL_EN to include SCROLL_UP; otherwise SCROLL_UP pulses err.
module text_scroll_ctrl_m #(
  parameter int ROWS = 30,
  parameter int COLS = 32
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [4:0] cmd_rows,
  input  logic [7:0] cmd_fill,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       txbl_we,
  output logic [9:0] txbl_addr,
  output logic [7:0] txbl_wdata,
  output logic [9:0] txbl_raddr,
  input  logic [7:0] txbl_rdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
`ifdef TEXT_SCROLL_EN
    S_SC_RD = 3'd2,
    S_SC_WR = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] row_q, row_d, col_q, col_d;
  logic [7:0] fill_q, fill_d;
  logic       err_q, err_d;
  logic       eng_we;
  logic [7:0] eng_data;
  logic       col_last;

  assign col_last = (col_q == 5'(COLS - 1));

`ifdef TEXT_SCROLL_EN
  logic [4:0] n_q, n_d;
  logic [5:0] src_row;
  // 6-bit sum so the source-row comparison cannot alias after truncation
  assign src_row = {1'b0, row_q} + {1'b0, n_q};
`else
  logic unused_ok;
  assign unused_ok = ^{cmd_rows, txbl_rdata};
`endif

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
`ifdef TEXT_SCROLL_EN
      n_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
`ifdef TEXT_SCROLL_EN
      n_q     <= n_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    fill_d  = fill_q;
    err_d   = 1'b0;
`ifdef TEXT_SCROLL_EN
    n_d     = n_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          fill_d = cmd_fill;
          row_d  = '0;
          col_d  = '0;
          if (!cmd_op) begin
            state_d = S_FILL;
          end else begin
`ifdef TEXT_SCROLL_EN
            n_d = cmd_rows;
            if (cmd_rows == 5'd0)                     state_d = S_DONE;
            else if ({1'b0, cmd_rows} >= 6'(ROWS))    state_d = S_FILL;
            else                                      state_d = S_SC_RD;
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      S_FILL: begin
        if (eng_we) begin
          col_d = col_q + 5'd1;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + 5'd1;
            if (row_q == 5'(ROWS - 1)) state_d = S_DONE;
          end
        end
      end
`ifdef TEXT_SCROLL_EN
      S_SC_RD: state_d = S_SC_WR;
      // A stalled write stays in SC_WR so the read port keeps re-reading the source cell
      S_SC_WR: begin
        if (eng_we) begin
          state_d = S_SC_RD;
          col_d   = col_q + 5'd1;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + 5'd1;
            if (src_row == 6'(ROWS - 1)) state_d = S_FILL;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_we     = 1'b0;
    eng_data   = fill_q;
    txbl_raddr = '0;
    if (state_q == S_FILL) eng_we = !cpu_we && !rst;
`ifdef TEXT_SCROLL_EN
    if (state_q == S_SC_WR) begin
      eng_we   = !cpu_we && !rst;
      eng_data = txbl_rdata;
    end
    if (state_q == S_SC_RD || state_q == S_SC_WR) txbl_raddr = {src_row[4:0], col_q};
`endif
    txbl_we    = cpu_we | eng_we;
    txbl_addr  = cpu_we ? cpu_addr  : {row_q, col_q};
    txbl_wdata = cpu_we ? cpu_wdata : eng_data;
    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE) && !rst;
    err        = err_q;
  end

endmodule

// File: tb/tb_text_scroll_ctrl_m.sv
// Scoreboard bench for text_scroll_ctrl_m with a write-first TXBL memory model.
module tb_text_scroll_ctrl_m;
  localparam int ROWS = 30;
  localparam int COLS = 32;

  logic       cpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [4:0] cmd_rows = '0;
  logic [7:0] cmd_fill = '0;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       txbl_we, busy, done, err;
  logic [9:0] txbl_addr, txbl_raddr;
  logic [7:0] txbl_wdata, txbl_rdata;

  logic [7:0] mem [0:1023];
  logic [7:0] exp_t [0:1023];
  int n_cmp = 0, n_err = 0, edges = 0, e0 = 0, eng_wr = 0;

  typedef struct { int addr; logic [7:0] val; } cell_t;
  int    done_q[$];
  cell_t cell_q[$];
  int         cw_cyc[$];
  logic [9:0] cw_addr[$];
  logic [7:0] cw_data[$];

  text_scroll_ctrl_m #(.ROWS(ROWS), .COLS(COLS)) dut (
    .cpu_clk(cpu_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rows(cmd_rows), .cmd_fill(cmd_fill), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .txbl_we(txbl_we), .txbl_addr(txbl_addr),
    .txbl_wdata(txbl_wdata), .txbl_raddr(txbl_raddr), .txbl_rdata(txbl_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) begin
    edges <= edges + 1;
    if (txbl_we) mem[txbl_addr] <= txbl_wdata;
    txbl_rdata <= (txbl_we && txbl_addr == txbl_raddr) ? txbl_wdata : mem[txbl_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input int s);
    return 8'(i * 7 + s * 29 + i / 32);
  endfunction

  always @(negedge cpu_clk) begin
    if (txbl_we && !cpu_we) eng_wr++;
    if (cpu_we) begin
      check_eq("pass_we", txbl_we, 1);
      check_eq("pass_addr", txbl_addr, cpu_addr);
      check_eq("pass_data", txbl_wdata, cpu_wdata);
    end
    if (err) check_eq("err_with_done", done, 0);
    if (done) begin
      if (done_q.size() == 0) check_eq("done_unexpected", done, 0);
      else check_eq("done_cycle", edges - e0 + 1, done_q.pop_front());
    end
  end

  task automatic preload(input int s);
    for (int i = 0; i < 1024; i++) begin
      cpu_we = 1'b1; cpu_addr = 10'(i); cpu_wdata = pat(i, s);
      @(posedge cpu_clk); #1;
    end
    cpu_we = 1'b0;
  endtask

  // Expected table after a CLEAR (n >= ROWS) or SCROLL_UP by n over pattern s.
  task automatic exp_scroll(input int s, input int n, input logic [7:0] fill);
    for (int i = 0; i < 1024; i++) begin
      int r;
      r = i / COLS;
      if (r >= ROWS || n == 0)  exp_t[i] = pat(i, s);
      else if (n >= ROWS)       exp_t[i] = fill;
      else if (r < ROWS - n)    exp_t[i] = pat(i + n * COLS, s);
      else                      exp_t[i] = fill;
    end
  endtask

  task automatic push_cells();
    for (int i = 0; i < 1024; i++) cell_q.push_back('{i, exp_t[i]});
  endtask

  task automatic add_cpu_wr(input int cyc, input logic [9:0] a, input logic [7:0] d);
    cw_cyc.push_back(cyc); cw_addr.push_back(a); cw_data.push_back(d);
    exp_t[a] = d;
  endtask

  task automatic drain_cells();
    while (cell_q.size() > 0) begin
      cell_t c;
      c = cell_q.pop_front();
      check_eq($sformatf("cell_%03h", c.addr), mem[c.addr], c.val);
    end
  endtask

  task automatic run_cmd(input logic op, input logic [4:0] n, input logic [7:0] fill,
                         input int exp_done, input int exp_wr, input int run_len, input int rst_cyc);
    int wr0;
    push_cells();
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rows = n; cmd_fill = fill;
    @(posedge cpu_clk); #1;
    e0 = edges; cmd_valid = 1'b0; wr0 = eng_wr;
    if (exp_done > 0) done_q.push_back(exp_done);
    for (int cyc = 1; cyc <= run_len; cyc++) begin
      cpu_we = 1'b0;
      foreach (cw_cyc[i]) if (cw_cyc[i] == cyc) begin
        cpu_we = 1'b1; cpu_addr = cw_addr[i]; cpu_wdata = cw_data[i];
      end
      rst = (cyc == rst_cyc);
      cmd_valid = (cyc == 20 && run_len > 40);
      if (cmd_valid) begin cmd_op = 1'b1; cmd_rows = 5'd0; end
      #1;
      if (cyc == 1) check_eq("busy_cycle1", busy, 1);
      if (exp_done > 0 && cyc == exp_done + 1) check_eq("ready_after_done", cmd_ready, 1);
      if (rst_cyc > 0 && cyc == rst_cyc + 1) check_eq("ready_after_rst", cmd_ready, 1);
      @(posedge cpu_clk); #1;
    end
    rst = 1'b0; cpu_we = 1'b0; cmd_valid = 1'b0;
    check_eq("done_pending", done_q.size(), 0);
    done_q.delete();
    check_eq("engine_writes", eng_wr - wr0, exp_wr);
    drain_cells();
    cw_cyc.delete(); cw_addr.delete(); cw_data.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, CPU passthrough active during reset
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_wdata = 8'hAB; cmd_valid = 1'b1;
    repeat (2) @(posedge cpu_clk);
    #1;
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_raddr", txbl_raddr, 0);
    check_eq("rst_we", txbl_we, 1);
    check_eq("rst_addr", txbl_addr, 10'h155);
    check_eq("rst_wdata", txbl_wdata, 8'hAB);
    rst = 1'b0; cpu_we = 1'b0; cmd_valid = 1'b0;
    #1;
    check_eq("idle_we", txbl_we, 0);
    @(posedge cpu_clk); #1;

`ifndef TEXT_SCROLL_EN
    begin
      int wr0;
      preload(3);
      exp_scroll(3, 0, 8'h00);
      push_cells();
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_rows = 5'd2; cmd_fill = 8'h99;
      @(posedge cpu_clk); #1;
      cmd_valid = 1'b0; wr0 = eng_wr;
      check_eq("err_cycle1", err, 1);
      check_eq("err_ready", cmd_ready, 1);
      check_eq("err_busy", busy, 0);
      @(posedge cpu_clk); #1;
      check_eq("err_cycle2", err, 0);
      repeat (8) begin @(posedge cpu_clk); #1; end
      check_eq("err_writes", eng_wr - wr0, 0);
      drain_cells();
    end
`endif

    // CLEAR, no stalls
    preload(1);
    exp_scroll(1, ROWS, 8'h85);
    run_cmd(1'b0, 5'd0, 8'h85, 961, 960, 962, 0);

    // CLEAR with 5 CPU stall cycles; cell 5 is refilled, cell 0 keeps the CPU value
    preload(2);
    exp_scroll(2, ROWS, 8'h33);
    add_cpu_wr(2,   10'h005, 8'h41);
    exp_t[5] = 8'h33;
    add_cpu_wr(10,  10'h3FF, 8'h41);
    add_cpu_wr(11,  10'h3FF, 8'h41);
    add_cpu_wr(500, 10'h000, 8'h41);
    add_cpu_wr(501, 10'h000, 8'h41);
    run_cmd(1'b0, 5'd0, 8'h33, 966, 960, 967, 0);

    // reset during cycle 400 of a CLEAR
    preload(3);
    for (int i = 0; i < 1024; i++) exp_t[i] = (i < 399) ? 8'h7E : pat(i, 3);
    run_cmd(1'b0, 5'd0, 8'h7E, -1, 399, 410, 400);

`ifdef TEXT_SCROLL_EN
    preload(4);
    exp_scroll(4, 3, 8'h20);
    run_cmd(1'b1, 5'd3, 8'h20, 2 * 27 * 32 + 96 + 1, 960, 1827, 0);

    preload(5);
    exp_scroll(5, 0, 8'h20);
    run_cmd(1'b1, 5'd0, 8'h20, 1, 0, 3, 0);

    preload(6);
    exp_scroll(6, 31, 8'h66);
    run_cmd(1'b1, 5'd31, 8'h66, 961, 960, 962, 0);

    // stalls in SC_RD cost nothing, stalls in SC_WR cost one cycle each
    preload(7);
    exp_scroll(7, 1, 8'hC3);
    add_cpu_wr(1, 10'h3E0, 8'h41);
    add_cpu_wr(2, 10'h3E0, 8'h41);
    add_cpu_wr(3, 10'h3E0, 8'h41);
    run_cmd(1'b1, 5'd1, 8'hC3, 1891, 960, 1892, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
